dma_engineer: RTL
=================

Name: dma_engineer

Overview:
- Responder end of the layer DMA interface: accepts a weight-fetch request (start address, length) from one layer controller, reads that many 512-bit words from off-chip memory, and streams them back with a valid strobe and an end-of-packet flag.
- Sits between a layer's weight double buffer and the memory read port; one request is served at a time.

Parameters:
- ADDR_W, 27, width of the word address and length (unit = one 512-bit word).
- DATA_W, 512, data beat width.
- MAX_OUTSTANDING, 8, maximum memory reads issued but not yet returned.
- CNT_W, 4, width of the outstanding counter; must hold MAX_OUTSTANDING.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- dma_engineer_req  input  1  request level, held by the requester until it sees ack.
- dma_engineer_ack  output  1  one-cycle acceptance pulse.
- dma_engineer_start_addr  input  ADDR_W  first word address; sampled when ack pulses.
- dma_engineer_length  input  ADDR_W  number of words; sampled when ack pulses.
- dma_engineer_dout  output  DATA_W  returned data beat.
- dma_engineer_dout_en  output  1  dout is valid this cycle.
- dma_engineer_dout_eop  output  1  marks the last beat of the request; qualified by dout_en.
- dma_engineer_busy  output  1  high from ack until the request completes.
- mem_rd_req  output  1  read command valid.
- mem_rd_addr  output  ADDR_W  read word address.
- mem_rd_gnt  input  1  memory accepts the command this cycle (transfer when req & gnt).
- mem_rd_valid  input  1  read data valid; data returns in issue order.
- mem_rd_data  input  DATA_W  read data.

Behaviour:
- Reset (rst=0, asynchronous):
  - all outputs are 0;
  - state is IDLE;
  - all counters are 0.
- State machine: IDLE -> ACK -> ISSUE -> DRAIN -> IDLE.
- IDLE:
  - if dma_engineer_req=1, go to ACK;
  - mem_rd_valid arriving in IDLE is dropped, with no dout_en.
- ACK (one cycle):
  - dma_engineer_ack=1;
  - latch start_addr into addr_q and length into remain_issue / remain_ret;
  - busy rises in the same cycle;
  - if length=0, go straight to IDLE: no beats, no eop, busy drops the next cycle.
- ISSUE:
  - mem_rd_req=1 while remain_issue>0 and outstanding<MAX_OUTSTANDING;
  - mem_rd_addr=addr_q;
  - on req&gnt: addr_q+1 (wraps modulo 2^ADDR_W), remain_issue-1, outstanding+1;
  - when remain_issue reaches 0, go to DRAIN.
- Outstanding counter:
  - +1 on each accepted command, -1 on each mem_rd_valid;
  - both in the same cycle: net 0;
  - at MAX_OUTSTANDING, mem_rd_req drops, and reasserts the cycle after a return frees a slot.
- Return path (ISSUE or DRAIN):
  - each mem_rd_valid is registered: dma_engineer_dout=mem_rd_data and dout_en=1 one cycle later (fixed latency 1);
  - remain_ret-1 per beat;
  - dout_eop=1 together with the beat for which remain_ret was 1.
- DRAIN: when the eop beat is emitted, busy drops the next cycle and the state returns to IDLE.
- dma_engineer_req seen high again in IDLE (back-to-back requests): the next ACK occurs no earlier than one cycle after busy falls.
- mem_rd_valid with remain_ret=0 (protocol violation): dropped.
- Reset mid-transfer: aborts immediately with no eop; memory returns still in flight are dropped in IDLE.
- No backpressure on dout; the requester must sink every beat.

Test Plan:
- Single word: req with start=1824, len=1, gnt tied to 1, data returned 3 cycles after issue → ack pulses once; one mem_rd_addr=1824; one dout_en beat with eop=1; busy falls the cycle after.
- Burst: start=100, len=20, gnt=1, valid latency 5 → addresses 100..119 issued in order; never more than 8 outstanding; 20 dout_en beats with data matching; eop only on beat 20.
- Backpressure: len=12, gnt low for 4 of every 5 cycles, random return latency 1-10 → data order preserved; mem_rd_req stays asserted until granted; exactly 12 beats.
- Address wrap: start=0x7FFFFFE, len=4 → addresses 0x7FFFFFE, 0x7FFFFFF, 0x0000000, 0x0000001.
- Length zero, then back-to-back: len=0 → ack and no dout_en; then an immediate second request with len=2 → served normally with 2 beats and eop on the second.
- Reset mid-burst: len=16, assert rst after 5 beats, release, then feed 3 late mem_rd_valid → all outputs 0 during reset, no dout_en after release, and a fresh len=1 request then completes.

Source files
------------

// File: rtl/dma_engineer.sv
// Weight-fetch DMA responder: serves one (start, length) request at a time by
// issuing in-order word reads to memory and streaming the returned beats back.
module dma_engineer #(
  parameter int ADDR_W          = 27,
  parameter int DATA_W          = 512,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_engineer_req,
  output logic              dma_engineer_ack,
  input  logic [ADDR_W-1:0] dma_engineer_start_addr,
  input  logic [ADDR_W-1:0] dma_engineer_length,
  output logic [DATA_W-1:0] dma_engineer_dout,
  output logic              dma_engineer_dout_en,
  output logic              dma_engineer_dout_eop,
  output logic              dma_engineer_busy,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_gnt,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data
);

  typedef enum logic [1:0] {IDLE, ACK, ISSUE, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, remain_issue, remain_ret;
  logic [CNT_W-1:0]  outstanding;
  logic              issue_fire, ret_fire;

  assign issue_fire = mem_rd_req & mem_rd_gnt;
  // Returns are only meaningful while a request still expects beats; anything else is stale.
  assign ret_fire   = mem_rd_valid && (state_q == ISSUE || state_q == DRAIN) &&
                      (remain_ret != '0);

  assign mem_rd_addr       = addr_q;
  assign dma_engineer_busy = (state_q != IDLE);

  always_comb begin
    state_d          = state_q;
    dma_engineer_ack = 1'b0;
    mem_rd_req       = 1'b0;
    case (state_q)
      IDLE:  if (dma_engineer_req) state_d = ACK;
      ACK: begin
        dma_engineer_ack = 1'b1;
        state_d = (dma_engineer_length == '0) ? IDLE : ISSUE;
      end
      ISSUE: begin
        mem_rd_req = (remain_issue != '0) && (outstanding < CNT_W'(MAX_OUTSTANDING));
        if (remain_issue == '0 || (issue_fire && remain_issue == ADDR_W'(1)))
          state_d = DRAIN;
      end
      DRAIN: if (dma_engineer_dout_en && dma_engineer_dout_eop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q               <= IDLE;
      addr_q                <= '0;
      remain_issue          <= '0;
      remain_ret            <= '0;
      outstanding           <= '0;
      dma_engineer_dout     <= '0;
      dma_engineer_dout_en  <= 1'b0;
      dma_engineer_dout_eop <= 1'b0;
    end else begin
      state_q               <= state_d;
      dma_engineer_dout_en  <= ret_fire;
      dma_engineer_dout_eop <= ret_fire && (remain_ret == ADDR_W'(1));
      if (ret_fire) begin
        dma_engineer_dout <= mem_rd_data;
        remain_ret        <= remain_ret - ADDR_W'(1);
      end
      if (state_q == ACK) begin
        addr_q       <= dma_engineer_start_addr;
        remain_issue <= dma_engineer_length;
        remain_ret   <= dma_engineer_length;
      end else if (issue_fire) begin
        addr_q       <= addr_q + ADDR_W'(1);
        remain_issue <= remain_issue - ADDR_W'(1);
      end
      // Simultaneous issue and return leave the count unchanged.
      case ({issue_fire, ret_fire})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   if (outstanding != '0) outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule
